// File: rtl/demux8_pkg.sv
// demux8_pkg -- shared constants and types for the 8-way dispatcher.
//   NUM_OUT : number of downstream sinks
//   SEL_W   : width of the demux select / round-robin pointer
//   CNT_W   : width of the optional dispatch counter
//   state_t : payload buffer FSM state (EMPTY = buffer invalid, FULL = valid)
package demux8_pkg;

    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8 -- combinational round-robin search over 8 requesters.
// Scans ptr_i, ptr_i+1, ... ptr_i+7 (mod 8) and returns the first index
// whose request bit is set.
//   req_i   [7:0] : request vector (one bit per sink)
//   ptr_i   [2:0] : highest-priority index
//   grant_o [2:0] : winning index (0 when any_o=0)
//   any_o         : at least one request is set
module rr_pick8
    import demux8_pkg::*;
(
    input  logic [NUM_OUT-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   grant_o,
    output logic               any_o
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            // Index arithmetic wraps naturally in SEL_W bits.
            idx = ptr_i + SEL_W'(k);
            if (!any_o && req_i[idx]) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8_dispatcher.sv
// demux8_dispatcher -- single-buffer dispatcher from one upstream stream to
// eight sinks, choosing the sink by round-robin among the ready ones.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The upstream side uses in_valid/in_ready. The downstream
// side is offer-on-ready: out_valid is one-hot only at a sink whose
// out_ready is already high, so any non-zero out_valid is a transfer that
// cycle. in_ready combinationally depends on out_ready so a new word can
// replace a word being dispatched in the same cycle (1 word/cycle).
//
// Ports:
//   clk                 : clock, rising edge
//   reset               : asynchronous, active-high
//   in_valid / in_ready : upstream handshake
//   in_data [DATA_W]    : upstream payload
//   out_valid[8]        : one-hot target sink (0 = no offer)
//   out_ready[8]        : per-sink accept
//   out_data [DATA_W]   : buffered payload, common to all sinks
//   sel[3]              : demux select {s2,s1,s0}; target index when
//                         dispatching, otherwise the round-robin pointer
//   dispatch_cnt[16]    : only when DEMUX8_DISPATCH_CNT_EN is defined;
//                         wrapping count of downstream transfers
//
// Build option: define DEMUX8_DISPATCH_CNT_EN to add dispatch_cnt.
module demux8_dispatcher
    import demux8_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data,
`ifdef DEMUX8_DISPATCH_CNT_EN
    output logic [CNT_W-1:0]   dispatch_cnt,
`endif
    output logic [SEL_W-1:0]   sel
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic [SEL_W-1:0]  grant;
    logic              any_rdy;
    logic              dn_xfer;
    logic              up_xfer;

    rr_pick8 u_pick (
        .req_i   (out_ready),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_rdy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        dn_xfer   = 1'b0;
        in_ready  = 1'b0;
        up_xfer   = 1'b0;
        out_valid = '0;
        sel       = ptr_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        buf_d     = buf_q;

        dn_xfer = (state_q == FULL) && any_rdy && !reset;
        // Gated by reset so nothing is accepted while reset is held.
        in_ready = !reset && ((state_q == EMPTY) || dn_xfer);
        up_xfer  = in_valid && in_ready;

        if (dn_xfer) begin
            out_valid = NUM_OUT'(1) << grant;
            sel       = grant;
            ptr_d     = grant + SEL_W'(1);
        end

        if (up_xfer) begin
            buf_d   = in_data;
            state_d = FULL;
        end else if (dn_xfer) begin
            state_d = EMPTY;
        end
    end

    assign out_data = buf_q;

`ifdef DEMUX8_DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (dn_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dispatch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux8_dispatcher.sv
// Bench for demux8_dispatcher: directed vector table, hand-written reset
// sequence, and randomized traffic against a behavioural model.
module tb_demux8_dispatcher;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] out_data;
    logic [2:0] sel;
`ifdef DEMUX8_DISPATCH_CNT_EN
    logic [15:0] dispatch_cnt;
`endif

    demux8_dispatcher #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX8_DISPATCH_CNT_EN
        .dispatch_cnt (dispatch_cnt),
`endif
        .sel       (sel)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters / checker ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [7:0] ordy;
        logic       e_rdy;
        logic [7:0] e_ov;
        logic [2:0] e_sel;
        logic       chk_data;
        logic [7:0] e_data;
        logic       rst_before;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_before, input logic iv, input logic [7:0] d,
                                input logic [7:0] ordy, input logic e_rdy, input logic [7:0] e_ov,
                                input logic [2:0] e_sel, input logic chk_data, input logic [7:0] e_data);
        vec_t v;
        v.rst_before = rst_before;
        v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sel = e_sel;
        v.chk_data = chk_data; v.e_data = e_data;
        vecs.push_back(v);
    endfunction

    // ---------------- reference model + scoreboard ----------------
    bit         m_full;
    logic [7:0] m_buf;
    int         m_ptr;
    logic [7:0] exp_q[$];

    // Hold reset for two edges, checking the reset-state outputs.
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 8'hFF;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_sel",       32'(sel),       32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_full = 0; m_buf = 8'h00; m_ptr = 0;
        exp_q.delete();
    endtask

    // Apply one cycle of random-phase stimulus; expectations come from the
    // model's view: a buffer, a pointer, and a priority scan over sinks.
    task automatic step(input logic iv, input logic [7:0] d, input logic [7:0] ordy);
        int         tgt;
        bit         dn;
        logic [7:0] e_ov;
        logic [2:0] e_sel;
        logic       e_rdy;
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        tgt = -1;
        if (m_full) begin
            for (int k = 0; k < 8; k++) begin
                if (tgt < 0 && ordy[(m_ptr + k) % 8]) tgt = (m_ptr + k) % 8;
            end
        end
        dn    = (tgt >= 0);
        e_ov  = dn ? 8'(1 << tgt) : 8'h00;
        e_sel = dn ? 3'(tgt) : 3'(m_ptr);
        e_rdy = !m_full || dn;
        check("rnd_out_valid", 32'(out_valid), 32'(e_ov));
        check("rnd_sel",       32'(sel),       32'(e_sel));
        check("rnd_in_ready",  32'(in_ready),  32'(e_rdy));
        if (m_full) check("rnd_out_data", 32'(out_data), 32'(m_buf));
        if (out_valid != 8'h00) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_dispatch", 32'(out_valid), 32'h0);
            end else begin
                check("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        if (dn) m_ptr = (tgt + 1) % 8;
        if (iv && e_rdy) begin
            exp_q.push_back(d);
            m_full = 1;
            m_buf  = d;
        end else if (dn) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    // ---------------- main ----------------
    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 8'h00;
        @(negedge clk);

        // Single word to sink 0, pointer then advances to 1.
        add(1, 1, 8'hA5, 8'hFF, 1, 8'h00, 3'd0, 0, 8'h00);
        add(0, 0, 8'h00, 8'hFF, 1, 8'h01, 3'd0, 1, 8'hA5);
        add(0, 0, 8'h00, 8'hFF, 1, 8'h00, 3'd1, 0, 8'h00);
        // Back-to-back words 0x10..0x18: sinks 0..7 then wrap to 0.
        add(1, 1, 8'h10, 8'hFF, 1, 8'h00, 3'd0, 0, 8'h00);
        for (int i = 1; i <= 8; i++)
            add(0, 1, 8'(8'h10 + i), 8'hFF, 1, 8'(1 << (i - 1)), 3'(i - 1), 1, 8'(8'h10 + i - 1));
        add(0, 0, 8'h00, 8'hFF, 1, 8'h01, 3'd0, 1, 8'h18);
        // Stall three cycles with ptr=1, then only sink 5 ready.
        add(0, 1, 8'h77, 8'h00, 1, 8'h00, 3'd1, 0, 8'h00);
        for (int i = 0; i < 3; i++)
            add(0, 1, 8'h99, 8'h00, 0, 8'h00, 3'd1, 1, 8'h77);
        add(0, 0, 8'h00, 8'h20, 1, 8'h20, 3'd5, 1, 8'h77);
        add(0, 0, 8'h00, 8'h00, 1, 8'h00, 3'd6, 0, 8'h00);
        // ptr=6 with sinks 0 and 6 ready: 6 wins, then 0 from ptr=7.
        add(0, 1, 8'hAA, 8'h41, 1, 8'h00, 3'd6, 0, 8'h00);
        add(0, 1, 8'hBB, 8'h41, 1, 8'h40, 3'd6, 1, 8'hAA);
        add(0, 0, 8'h00, 8'h41, 1, 8'h01, 3'd0, 1, 8'hBB);
        add(0, 0, 8'h00, 8'h00, 1, 8'h00, 3'd1, 0, 8'h00);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_sel", i),       32'(sel),       32'(vecs[i].e_sel));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_data));
            @(negedge clk);
        end

        // Reset while FULL with 0x3C: word must be dropped.
        do_reset();
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_stall_data", 32'(out_data), 32'h3C);
        #1;
        reset = 1'b1;
        out_ready = 8'hFF;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_in_ready",  32'(in_ready),  32'h0);
        check("mid_rst_out_data",  32'(out_data),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_dispatch", 32'(out_valid), 32'h0);
            check("post_rst_sel",         32'(sel),       32'h0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            // Bias toward sparse ready patterns to exercise stalls and skips.
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            else if ($urandom_range(0, 1) == 0) r = r & 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), r);
        end

`ifdef DEMUX8_DISPATCH_CNT_EN
        do_reset();
        check("cnt_reset", 32'(dispatch_cnt), 32'h0);
        in_valid = 1'b1; out_ready = 8'hFF;
        for (int i = 0; i < 65538; i++) begin
            in_data = 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 8'h00;
        #1;
        check("cnt_wrap", 32'(dispatch_cnt), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux8_dispatcher.md
DEMUX8_DISPATCHER -- requirements
Module: demux8_dispatcher

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  dispatcher can accept a word this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-007 SHALL have port out_valid  output  8  one-hot; bit k means payload offered to sink k.
REQ-008 SHALL have port out_ready  input  8  bit k means sink k accepts this cycle.
REQ-009 SHALL have port out_data  output  DATA_W  buffered payload, common to all sinks.
REQ-010 SHALL have port sel  output  3  demux select {s2,s1,s0}; equals index of the targeted sink.

Function
REQ-011 SHALL hold one payload buffer and a 2-state FSM: EMPTY (buffer invalid), FULL (buffer valid).
REQ-012 SHALL define upstream transfer as in_valid & in_ready at a clock edge; the buffer captures in_data.
REQ-013 SHALL keep a 3-bit round-robin pointer ptr; ptr names the highest-priority sink.
REQ-014 In FULL, SHALL choose target = first index k scanning ptr, ptr+1, ... ptr+7 (mod 8) with out_ready[k]=1.
REQ-015 In FULL with a target, SHALL drive out_valid one-hot at target, sel=target; a downstream transfer occurs that cycle.
REQ-016 In FULL with no sink ready, SHALL drive out_valid=0, sel=ptr, keep buffer and ptr unchanged.
REQ-017 In EMPTY, SHALL drive out_valid=0, sel=ptr.
REQ-018 On downstream transfer, SHALL set ptr <= target+1 mod 8 (wrap 7->0).
REQ-019 SHALL drive in_ready = EMPTY | (FULL & downstream transfer this cycle); in_ready combinationally depends on out_ready.
REQ-020 Transitions: EMPTY->FULL on upstream transfer; FULL->EMPTY on downstream transfer without upstream transfer; FULL->FULL on simultaneous transfers (new word replaces old) or when stalled.
REQ-021 Latency: a word accepted at edge N SHALL be offered no earlier than the cycle after edge N; sustained throughput 1 word/cycle.
REQ-022 out_data SHALL equal buffer contents whenever out_valid!=0 and SHALL not change while FULL and stalled.

Reset
REQ-023 While reset=1: FSM=EMPTY, ptr=0, buffer=0, out_valid=0, sel=0, in_ready=0, out_data=0.
REQ-024 Reset asserted mid-transfer SHALL discard the buffered word; no partial dispatch after release.
REQ-025 First in_ready=1 SHALL appear in the first cycle after reset deasserts.

Configuration
REQ-026 Macro DEMUX8_DISPATCH_CNT_EN defined: SHALL add output dispatch_cnt (16 bits), incremented on each downstream transfer, wrapping 0xFFFF->0, reset to 0.
REQ-027 Macro undefined: dispatch_cnt port and its register SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package demux8_pkg SHALL hold NUM_OUT=8, SEL_W=3, CNT_W=16 and the FSM state typedef {EMPTY, FULL}.
REQ-029 Round-robin search SHALL be a sub-module rr_pick8 (inputs req[7:0], ptr[2:0]; outputs grant index[2:0], any).
REQ-030 sel SHALL be connectable directly to the existing 8-way demux select inputs (s2=sel[2], s1=sel[1], s0=sel[0]).

Verification
REQ-031 Reset then in_valid=1, data 0xA5, out_ready=0xFF -> in_ready=1; next cycle out_valid=0x01, sel=0, out_data=0xA5; ptr becomes 1.
REQ-032 Eight back-to-back words 0x10..0x17, out_ready=0xFF -> dispatched to sinks 0..7 in order, one per cycle, then word 9 to sink 0 (wrap).
REQ-033 Buffer FULL, out_ready=0x00 for 3 cycles -> out_valid=0, in_ready=0, out_data stable; then out_ready=0x20 -> out_valid=0x20, sel=5, ptr becomes 6.
REQ-034 ptr=6, out_ready=0x41 -> target 6 (not 0); next word with out_ready=0x41 -> target 0.
REQ-035 Reset pulsed while FULL with 0x3C -> out_valid=0 immediately, 0x3C never dispatched, ptr=0 after release.
REQ-036 With DEMUX8_DISPATCH_CNT_EN, 65537 dispatches -> dispatch_cnt=1.
